// File: rtl/fpro_bus_arbiter.sv
// Two-master arbiter for the FPro MMIO bus: samples held requests in IDLE,
// issues one single-cycle strobe in ISSUE and returns a one-cycle ack in DONE.
module fpro_bus_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  output logic                  m0_ack,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mmio_cs,
  output logic                  mmio_write,
  output logic                  mmio_read,
  output logic [ADDR_WIDTH-1:0] mmio_addr,
  output logic [DATA_WIDTH-1:0] mmio_wr_data,
  input  logic [DATA_WIDTH-1:0] mmio_rd_data,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;      // 1 = m1 was served last
  logic [1:0]            grant_q, grant_d;
  logic                  cs_q, cs_d;
  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  busy_q, busy_d;
  logic                  pick_m1;

  always_comb begin
    // m1 wins when it is alone, or under round-robin when m0 was served last
    pick_m1   = m1_req & (~m0_req | (~FIXED_PRIO & ~last_q));
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    cs_d      = 1'b0;
    write_d   = 1'b0;
    read_d    = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = S_ISSUE;
          last_d  = pick_m1;
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          addr_d  = pick_m1 ? m1_addr : m0_addr;
          wdata_d = pick_m1 ? m1_wr_data : m0_wr_data;
          write_d = pick_m1 ? m1_wr : m0_wr;
          read_d  = pick_m1 ? ~m1_wr : ~m0_wr;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (read_q) begin
          rd_data_d = mmio_rd_data;
        end
        ack0_d  = grant_q[0];
        ack1_d  = grant_q[1];
        state_d = S_DONE;
      end
      S_DONE: begin
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      grant_q   <= '0;
      cs_q      <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      cs_q      <= cs_d;
      write_q   <= write_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
    end
  end

  assign m0_ack       = ack0_q;
  assign m1_ack       = ack1_q;
  assign rd_data      = rd_data_q;
  assign mmio_cs      = cs_q;
  assign mmio_write   = write_q;
  assign mmio_read    = read_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;
  assign grant        = grant_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Directed bench for fpro_bus_arbiter: a round-robin and a fixed-priority
// instance share one set of master/slot stimulus.
module tb_fpro_bus_arbiter;
  localparam int AW = 21;
  localparam int DW = 32;

  typedef struct packed {
    logic          m0_req;
    logic          m0_wr;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m1_req;
    logic          m1_wr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] slot;
  } ins_t;

  typedef struct packed {
    logic          cs;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    grant;
    logic          ack0;
    logic          ack1;
    logic          busy;
    logic [DW-1:0] rdata;
  } outs_t;

  typedef struct packed {
    ins_t  in;
    outs_t exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data, mmio_rd_data;

  logic          rr_ack0, rr_ack1, rr_cs, rr_wr, rr_rd, rr_busy;
  logic [DW-1:0] rr_rdata, rr_wdata;
  logic [AW-1:0] rr_addr;
  logic [1:0]    rr_grant;
  logic          fp_ack0, fp_ack1, fp_cs, fp_wr, fp_rd, fp_busy;
  logic [DW-1:0] fp_rdata, fp_wdata;
  logic [AW-1:0] fp_addr;
  logic [1:0]    fp_grant;
  outs_t         rr_o, fp_o;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[15];

  always #5 clk = ~clk;

  fpro_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m0_ack(rr_ack0), .m1_ack(rr_ack1), .rd_data(rr_rdata),
    .mmio_cs(rr_cs), .mmio_write(rr_wr), .mmio_read(rr_rd), .mmio_addr(rr_addr),
    .mmio_wr_data(rr_wdata), .mmio_rd_data(mmio_rd_data),
    .grant(rr_grant), .busy(rr_busy)
  );

  fpro_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m0_ack(fp_ack0), .m1_ack(fp_ack1), .rd_data(fp_rdata),
    .mmio_cs(fp_cs), .mmio_write(fp_wr), .mmio_read(fp_rd), .mmio_addr(fp_addr),
    .mmio_wr_data(fp_wdata), .mmio_rd_data(mmio_rd_data),
    .grant(fp_grant), .busy(fp_busy)
  );

  always_comb begin
    rr_o.cs = rr_cs;   rr_o.wr = rr_wr;       rr_o.rd = rr_rd;       rr_o.addr = rr_addr;
    rr_o.wdata = rr_wdata; rr_o.grant = rr_grant; rr_o.ack0 = rr_ack0; rr_o.ack1 = rr_ack1;
    rr_o.busy = rr_busy;   rr_o.rdata = rr_rdata;
    fp_o.cs = fp_cs;   fp_o.wr = fp_wr;       fp_o.rd = fp_rd;       fp_o.addr = fp_addr;
    fp_o.wdata = fp_wdata; fp_o.grant = fp_grant; fp_o.ack0 = fp_ack0; fp_o.ack1 = fp_ack1;
    fp_o.busy = fp_busy;   fp_o.rdata = fp_rdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input outs_t act, input outs_t exp);
    chk({tag, ".cs"}, 64'(act.cs), 64'(exp.cs));
    chk({tag, ".write"}, 64'(act.wr), 64'(exp.wr));
    chk({tag, ".read"}, 64'(act.rd), 64'(exp.rd));
    chk({tag, ".addr"}, 64'(act.addr), 64'(exp.addr));
    chk({tag, ".wr_data"}, 64'(act.wdata), 64'(exp.wdata));
    chk({tag, ".grant"}, 64'(act.grant), 64'(exp.grant));
    chk({tag, ".m0_ack"}, 64'(act.ack0), 64'(exp.ack0));
    chk({tag, ".m1_ack"}, 64'(act.ack1), 64'(exp.ack1));
    chk({tag, ".busy"}, 64'(act.busy), 64'(exp.busy));
    chk({tag, ".rd_data"}, 64'(act.rdata), 64'(exp.rdata));
  endtask

  function automatic ins_t mk_i(input logic r0, input logic w0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic r1, input logic w1,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic [DW-1:0] slot);
    ins_t i;
    i.m0_req = r0; i.m0_wr = w0; i.m0_addr = a0; i.m0_wdata = d0;
    i.m1_req = r1; i.m1_wr = w1; i.m1_addr = a1; i.m1_wdata = d1;
    i.slot = slot;
    return i;
  endfunction

  function automatic outs_t mk_o(input logic cs, input logic w, input logic r,
                                 input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic [1:0] g, input logic a0, input logic a1,
                                 input logic b, input logic [DW-1:0] rd);
    outs_t o;
    o.cs = cs; o.wr = w; o.rd = r; o.addr = a; o.wdata = wd;
    o.grant = g; o.ack0 = a0; o.ack1 = a1; o.busy = b; o.rdata = rd;
    return o;
  endfunction

  task automatic apply(input ins_t i);
    m0_req = i.m0_req; m0_wr = i.m0_wr; m0_addr = i.m0_addr; m0_wr_data = i.m0_wdata;
    m1_req = i.m1_req; m1_wr = i.m1_wr; m1_addr = i.m1_addr; m1_wr_data = i.m1_wdata;
    mmio_rd_data = i.slot;
  endtask

  initial begin
    outs_t zero_o;
    ins_t  idle_i;
    ins_t  i_w0, i_r1, i_r0, i_w1;
    zero_o = mk_o(0, 0, 0, '0, '0, 2'b00, 0, 0, 0, '0);
    idle_i = mk_i(0, 0, '0, '0, 0, 0, '0, '0, '0);

    // Each vector: inputs during cycle k, expected outputs during cycle k+1
    i_w0 = mk_i(1, 1, 21'h00041, 32'hDEADBEEF, 0, 0, '0, '0, 32'h0);
    i_r1 = mk_i(0, 0, '0, '0, 1, 0, 21'h00100, 32'h11112222, 32'h0);
    i_r0 = mk_i(1, 0, 21'h00200, 32'h0, 0, 0, '0, '0, 32'h0);
    i_w1 = mk_i(0, 0, '0, '0, 1, 1, 21'h00300, 32'hCAFEF00D, 32'hFFFFFFFF);
    vecs[0]  = '{i_w0, mk_o(1, 1, 0, 21'h00041, 32'hDEADBEEF, 2'b01, 0, 0, 1, 32'h0)};
    vecs[1]  = '{i_w0, mk_o(0, 0, 0, 21'h00041, 32'hDEADBEEF, 2'b01, 1, 0, 1, 32'h0)};
    vecs[2]  = '{i_w0, mk_o(0, 0, 0, 21'h00041, 32'hDEADBEEF, 2'b00, 0, 0, 0, 32'h0)};
    vecs[3]  = '{idle_i, mk_o(0, 0, 0, 21'h00041, 32'hDEADBEEF, 2'b00, 0, 0, 0, 32'h0)};
    vecs[4]  = '{i_r1, mk_o(1, 0, 1, 21'h00100, 32'h11112222, 2'b10, 0, 0, 1, 32'h0)};
    i_r1.slot = 32'h0000A5A5;
    vecs[5]  = '{i_r1, mk_o(0, 0, 0, 21'h00100, 32'h11112222, 2'b10, 0, 1, 1, 32'h0000A5A5)};
    vecs[6]  = '{i_r1, mk_o(0, 0, 0, 21'h00100, 32'h11112222, 2'b00, 0, 0, 0, 32'h0000A5A5)};
    vecs[7]  = '{idle_i, mk_o(0, 0, 0, 21'h00100, 32'h11112222, 2'b00, 0, 0, 0, 32'h0000A5A5)};
    vecs[8]  = '{i_r0, mk_o(1, 0, 1, 21'h00200, 32'h0, 2'b01, 0, 0, 1, 32'h0000A5A5)};
    i_r0.slot = 32'h12345678;
    vecs[9]  = '{i_r0, mk_o(0, 0, 0, 21'h00200, 32'h0, 2'b01, 1, 0, 1, 32'h12345678)};
    vecs[10] = '{i_r0, mk_o(0, 0, 0, 21'h00200, 32'h0, 2'b00, 0, 0, 0, 32'h12345678)};
    vecs[11] = '{i_w1, mk_o(1, 1, 0, 21'h00300, 32'hCAFEF00D, 2'b10, 0, 0, 1, 32'h12345678)};
    vecs[12] = '{i_w1, mk_o(0, 0, 0, 21'h00300, 32'hCAFEF00D, 2'b10, 0, 1, 1, 32'h12345678)};
    vecs[13] = '{i_w1, mk_o(0, 0, 0, 21'h00300, 32'hCAFEF00D, 2'b00, 0, 0, 0, 32'h12345678)};
    vecs[14] = '{idle_i, mk_o(0, 0, 0, 21'h00300, 32'hCAFEF00D, 2'b00, 0, 0, 0, 32'h12345678)};

    // Reset values
    reset_n = 1'b0;
    apply(idle_i);
    tick();
    tick();
    check_outs("reset_held_rr", rr_o, zero_o);
    reset_n = 1'b1;
    tick();
    check_outs("reset_rel_rr", rr_o, zero_o);
    check_outs("reset_rel_fp", fp_o, zero_o);
    $display("reset: checked outputs after release");

    // Single write, single read, read followed by write
    for (int k = 0; k < 15; k++) begin
      apply(vecs[k].in);
      tick();
      check_outs($sformatf("vec%0d", k), rr_o, vecs[k].exp);
      $display("vec%0d: grant=%b cs=%b wr=%b rd=%b addr=%h ack=%b%b rd_data=%h",
               k, rr_grant, rr_cs, rr_wr, rr_rd, rr_addr, rr_ack1, rr_ack0, rr_rdata);
    end

    // Asynchronous reset in the ISSUE cycle of a read drops it with no ack
    apply(mk_i(1, 0, 21'h00055, 32'h0, 0, 0, '0, '0, 32'h77777777));
    tick();
    chk("async_pre.cs", 64'(rr_cs), 64'(1));
    chk("async_pre.read", 64'(rr_rd), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check_outs("async_rst_rr", rr_o, zero_o);
    check_outs("async_rst_fp", fp_o, zero_o);
    tick();
    apply(idle_i);
    reset_n = 1'b1;
    tick();
    tick();
    chk("async_post.m0_ack", 64'(rr_ack0), 64'(0));
    chk("async_post.busy", 64'(rr_busy), 64'(0));
    $display("async reset: outputs cleared mid-cycle, transaction dropped");

    // Sustained contention straight out of reset; both instances see the same masters
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    apply(mk_i(1, 1, 21'h00010, 32'h000000A0, 1, 0, 21'h00020, 32'h0, 32'h0BADF00D));
    for (int k = 1; k <= 14; k++) begin
      int phase;
      int owner;
      logic [1:0] exp_g;
      tick();
      phase = k % 3;
      owner = ((k - 1) / 3) % 2;
      if (k <= 12) begin
        exp_g = (phase == 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
        chk($sformatf("rr%0d.grant", k), 64'(rr_grant), 64'(exp_g));
        chk($sformatf("rr%0d.m0_ack", k), 64'(rr_ack0), 64'(phase == 2 && owner == 0));
        chk($sformatf("rr%0d.m1_ack", k), 64'(rr_ack1), 64'(phase == 2 && owner == 1));
        chk($sformatf("rr%0d.busy", k), 64'(rr_busy), 64'(phase != 0));
        if (k == 5) chk("rr5.rd_data", 64'(rr_rdata), 64'(32'h0BADF00D));
        chk($sformatf("fp%0d.grant", k), 64'(fp_grant), 64'((phase == 0) ? 2'b00 : 2'b01));
        chk($sformatf("fp%0d.m0_ack", k), 64'(fp_ack0), 64'(phase == 2));
        chk($sformatf("fp%0d.m1_ack", k), 64'(fp_ack1), 64'(0));
      end else begin
        chk($sformatf("fp%0d.grant", k), 64'(fp_grant), 64'(2'b10));
        chk($sformatf("fp%0d.m0_ack", k), 64'(fp_ack0), 64'(0));
        chk($sformatf("fp%0d.m1_ack", k), 64'(fp_ack1), 64'(k == 14));
      end
      $display("cycle N+%0d: rr grant=%b ack=%b%b | fp grant=%b ack=%b%b",
               k, rr_grant, rr_ack1, rr_ack0, fp_grant, fp_ack1, fp_ack0);
      // m0 was just acked by the fixed-priority instance; let it go
      if (k == 12) m0_req = 1'b0;
    end
    apply(idle_i);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpro_bus_arbiter.md
# fpro_bus_arbiter

- Two-master arbiter for the FPro MMIO bus.
- Lets a second bus master (DMA or hardware sequencer) share the MMIO slot bus with the MicroBlaze-side bridge.
- Sits between the two masters and `MMIO_Wrapper`. Accepts held request/acknowledge transactions from each master, selects one by round-robin or fixed priority, and issues it as a single-cycle FPro strobe.
- Returns the read data and a one-cycle acknowledge to the winning master.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 21: FPro MMIO address width.
- `DATA_WIDTH`, default 32: bus data width.
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = m0 always wins contention.

**Ports**
- `clk` in 1: system clock. All logic is on `clk`, one clock only.
- `reset_n` in 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` in 1 each: request. Held high until the matching ack.
- `m0_wr`, `m1_wr` in 1 each: 1 = write, 0 = read. Held stable with req.
- `m0_addr`, `m1_addr` in `ADDR_WIDTH` each: target address. Held stable with req.
- `m0_wr_data`, `m1_wr_data` in `DATA_WIDTH` each: write data. Held stable with req.
- `m0_ack`, `m1_ack` out 1 each: one-cycle completion pulse.
- `rd_data` out `DATA_WIDTH`: shared read return. Valid only in an ack cycle of a read.
- `mmio_cs` out 1: FPro MMIO chip select.
- `mmio_write`, `mmio_read` out 1 each: FPro strobes.
- `mmio_addr` out `ADDR_WIDTH`: FPro address.
- `mmio_wr_data` out `DATA_WIDTH`: FPro write data.
- `mmio_rd_data` in `DATA_WIDTH`: combinational read data from the slots.
- `grant` out 2: one-hot, owner of the current transaction; 00 when idle.
- `busy` out 1: high in ISSUE and DONE.

## Operation

**States:** IDLE, ISSUE, DONE. Transitions are unconditional except in IDLE.

**IDLE**
- Samples `m0_req` and `m1_req`. Neither high: stay in IDLE.
- One high: grant it.
- Both high:
  - `FIXED_PRIO=1`: grant m0.
  - `FIXED_PRIO=0`: grant the master not recorded in `last`.
- On any grant:
  - Register the winner's addr, wr_data and wr into the bus output registers.
  - Set `grant`.
  - Update `last` to the winner.
  - Go to ISSUE.

**ISSUE**
- `mmio_cs=1` and exactly one of `mmio_write` or `mmio_read` is 1, for this cycle only.
- On a read, capture `mmio_rd_data` into the `rd_data` register at the end of this cycle.
- Go to DONE.

**DONE**
- Strobes and cs return to 0. The granted master's ack is 1 for this cycle only.
- `rd_data` holds the captured value. Writes do not update `rd_data`.
- Requests are not sampled in DONE. Go to IDLE; `grant` clears on entry to IDLE.

**Requester rules**
- A requester drops req, or presents a new command, in the cycle after its ack.
- Any req high in an IDLE cycle is a new request.
- Changing the command while req is high and un-acked is illegal; behaviour is undefined.
- The losing master keeps req high and is served in the next IDLE.
- `mmio_addr` and `mmio_wr_data` hold their last value when not in ISSUE. Slots qualify them with `mmio_cs`.

**Reset**
- Any time `reset_n` goes low: state to IDLE and `last` to m1, so m0 wins the first contention.
- All outputs go to 0: `mmio_*`, acks, `grant`, `busy`, `rd_data`.
- An in-flight transaction is dropped with no ack. The requester must re-issue after reset.

## Timing

- Latency from req high in IDLE (cycle N) to ack: ack is high in cycle N+2. The strobe is in cycle N+1.
- Each transaction occupies three cycles, so the next grant is sampled in cycle N+3. Peak throughput is one transaction per 3 cycles.
- Sustained contention with round-robin: grants strictly alternate m0, m1, m0, … Each master waits at most 3 extra cycles.
- All outputs are registered. No combinational path from any `m*` input or `mmio_rd_data` to any output.
- Read data is sampled from the combinational slot read mux in the ISSUE cycle.

## Test plan

1. **Reset values.** Hold `reset_n=0`, then release. Required: all outputs 0 and `busy=0`. Assert reset during ISSUE of a read: no ack, outputs 0 immediately, even without a clock edge.
2. **Single m0 write.** m0 writes addr 0x00041 with data 0xDEADBEEF. Required: `mmio_cs=1`, `mmio_write=1`, `mmio_addr=0x00041`, `mmio_wr_data=0xDEADBEEF` for exactly one cycle (N+1). `m0_ack` pulses at N+2; `m1_ack` stays 0.
3. **Single m1 read.** m1 reads with the slot model returning 0x0000A5A5 during ISSUE. Required: `mmio_read=1` for one cycle; `rd_data=0x0000A5A5` with `m1_ack` at N+2; `grant=10` during ISSUE and DONE.
4. **Round-robin contention.** `FIXED_PRIO=0`; both masters request simultaneously right after reset and hold req, re-requesting after each ack, for 4 transactions. Required: grant order m0, m1, m0, m1; acks at cycles N+2, N+5, N+8, N+11.
5. **Fixed priority.** `FIXED_PRIO=1` with both masters requesting continuously. Required: only m0 is served. When m0 drops req, m1's ack arrives 2 cycles after the next IDLE.
6. **Write does not clobber read data.** m0 read returns 0x12345678, then an m1 write follows. Required: `rd_data` remains 0x12345678 through the write's ack cycle.
